// File: rtl/obi_pkg.sv
// Shared OBI bus types and the platform defaults used to size the bank arbiter.
package obi_pkg;
  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;
endpackage

package cei_mochila_pkg;
  localparam int unsigned ARB_NMASTER         = 3;
  localparam int unsigned ARB_MAX_OUTSTANDING = 2;
endpackage

// File: rtl/arb_id_fifo.sv
// In-order queue of master IDs for transactions granted but not yet answered.
module arb_id_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 2
) (
  input  logic             gclk,
  input  logic             grst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [PW-1:0]               wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]               cnt_q;
  logic                        do_push, do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

// File: rtl/obi_rr_bank_arbiter.sv
// Round-robin share of one OBI slave among NMASTER masters; responses are routed
// back in issue order through an ID FIFO, and a stalled selection is held until granted.
module obi_rr_bank_arbiter
  import obi_pkg::*;
#(
  parameter int NMASTER         = int'(cei_mochila_pkg::ARB_NMASTER),
  parameter int MAX_OUTSTANDING = int'(cei_mochila_pkg::ARB_MAX_OUTSTANDING)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  obi_req_t  [NMASTER-1:0]  master_req_i,
  output obi_resp_t [NMASTER-1:0]  master_resp_o,
  output obi_req_t                 slave_req_o,
  input  obi_resp_t                slave_resp_i,
  output logic                     protocol_err_o
);
  localparam int IDW = $clog2(NMASTER);

  logic [IDW-1:0] rr_ptr_q, lock_idx_q, win_idx, head_id;
  logic [IDW:0]   scan;
  logic           lock_q, err_q;
  logic           win_vld, issue, hs, stall, rsp_pop;
  logic           fifo_full, fifo_empty;

  // Winner: held index while locked, else first requester at or after rr_ptr.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    scan    = '0;
    if (lock_q) begin
      win_idx = lock_idx_q;
      win_vld = master_req_i[lock_idx_q].req;
    end else begin
      for (int k = 0; k < NMASTER; k++) begin
        scan = {1'b0, rr_ptr_q} + (IDW+1)'(k);
        if (scan >= (IDW+1)'(NMASTER)) scan = scan - (IDW+1)'(NMASTER);
        if (!win_vld && master_req_i[scan[IDW-1:0]].req) begin
          win_vld = 1'b1;
          win_idx = scan[IDW-1:0];
        end
      end
    end
  end

  // Reset gates the outputs so they drop immediately, not at the next edge.
  always_comb begin
    issue       = rst_ni && win_vld && !fifo_full;
    hs          = issue && slave_resp_i.gnt;
    stall       = issue && !slave_resp_i.gnt;
    rsp_pop     = slave_resp_i.rvalid && !fifo_empty;
    slave_req_o = '0;
    if (issue) slave_req_o = master_req_i[win_idx];
  end

  always_comb begin
    for (int i = 0; i < NMASTER; i++) begin
      master_resp_o[i] = '0;
      if (rst_ni) begin
        master_resp_o[i].rdata  = slave_resp_i.rdata;
        master_resp_o[i].gnt    = hs && (win_idx == IDW'(i));
        master_resp_o[i].rvalid = rsp_pop && (head_id == IDW'(i));
      end
    end
  end

  assign protocol_err_o = err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q   <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (hs) begin
        rr_ptr_q <= (win_idx == IDW'(NMASTER - 1)) ? '0 : win_idx + IDW'(1);
        lock_q   <= 1'b0;
      end else if (stall) begin
        lock_q     <= 1'b1;
        lock_idx_q <= win_idx;
      end
      if (slave_resp_i.rvalid && fifo_empty) err_q <= 1'b1;
    end
  end

  arb_id_fifo #(
    .WIDTH (IDW),
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .gclk   (clk_i),
    .grst_n (rst_ni),
    .push   (hs),
    .wdata  (win_idx),
    .pop    (rsp_pop),
    .head   (head_id),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );
endmodule

// File: tb/tb_obi_rr_bank_arbiter.sv
// Directed bench for obi_rr_bank_arbiter against a queue-based reference model.
module tb_obi_rr_bank_arbiter;
  import obi_pkg::*;
  localparam int N  = 3;
  localparam int MO = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  obi_req_t  [N-1:0] mreq;
  obi_resp_t [N-1:0] mresp;
  obi_req_t          sreq;
  obi_resp_t         sresp;
  logic              perr;

  int vectors = 0, miscompares = 0;

  int mq[$];
  int m_rr, m_lidx;
  bit m_lock, m_err;
  int gnt_log[$], rv_log[$];
  logic [31:0] rv_data[$];

  always #5 clk = ~clk;

  obi_rr_bank_arbiter #(.NMASTER(N), .MAX_OUTSTANDING(MO)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .master_req_i   (mreq),
    .master_resp_o  (mresp),
    .slave_req_o    (sreq),
    .slave_resp_i   (sresp),
    .protocol_err_o (perr)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Model: pending-ID queue, priority pointer, held selection, sticky error.
  always @(negedge clk) begin : cmp
    obi_req_t          es;
    obi_resp_t [N-1:0] er;
    int w;
    bit has, iss, emp;
    es = '0; er = '0; w = 0; has = 0; iss = 0; emp = 1;
    if (!rst_n) begin
      mq.delete(); m_rr = 0; m_lock = 0; m_lidx = 0; m_err = 0;
    end else begin
      if (m_lock) begin
        w = m_lidx; has = mreq[w].req;
      end else begin
        for (int k = 0; k < N; k++)
          if (!has && mreq[(m_rr + k) % N].req) begin has = 1; w = (m_rr + k) % N; end
      end
      iss = has && (mq.size() < MO);
      if (iss) es = mreq[w];
      for (int i = 0; i < N; i++) begin
        er[i].rdata = sresp.rdata;
        er[i].gnt   = iss && sresp.gnt && (i == w);
      end
      emp = (mq.size() == 0);
      if (sresp.rvalid && !emp) er[mq[0]].rvalid = 1'b1;
    end
    vectors += 3;
    if (sreq !== es) begin
      miscompares++; $display("FAIL slave_req @%0t: got %h want %h", $time, sreq, es);
    end
    if (mresp !== er) begin
      miscompares++; $display("FAIL master_resp @%0t: got %h want %h", $time, mresp, er);
    end
    if (perr !== m_err) begin
      miscompares++; $display("FAIL protocol_err @%0t: got %b want %b", $time, perr, m_err);
    end
    for (int i = 0; i < N; i++) begin
      if (mresp[i].gnt) gnt_log.push_back(i);
      if (mresp[i].rvalid) begin rv_log.push_back(i); rv_data.push_back(mresp[i].rdata); end
    end
    if (rst_n) begin
      if (sresp.rvalid) begin
        if (emp) m_err = 1;
        else void'(mq.pop_front());
      end
      if (iss && sresp.gnt) begin
        mq.push_back(w); m_rr = (w + 1) % N; m_lock = 0;
      end else if (iss) begin
        m_lock = 1; m_lidx = w;
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic clear_logs();
    gnt_log.delete(); rv_log.delete(); rv_data.delete();
  endtask

  function automatic int at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  initial begin
    int e1[6];
    logic [31:0] last;
    logic any_rv;
    mreq = '0; sresp = '0; rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_slave_req", {63'd0, sreq.req}, 64'd0);
    chk("rst_err", {63'd0, perr}, 64'd0);
    rst_n = 1'b1;
    cyc();

    // Fair rotation: every master requests, slave grants each cycle, rdata = addr.
    clear_logs();
    for (int i = 0; i < N; i++) begin
      mreq[i].req = 1'b1; mreq[i].be = 4'hf; mreq[i].addr = 32'h10 * (i + 1);
    end
    last = '0;
    for (int c = 0; c < 7; c++) begin
      sresp.gnt = (c < 6); sresp.rvalid = (c > 0); sresp.rdata = (c > 0) ? last : '0;
      if (c == 6) for (int i = 0; i < N; i++) mreq[i].req = 1'b0;
      @(negedge clk); last = sreq.addr;
      cyc();
    end
    sresp = '0;
    e1 = '{0, 1, 2, 0, 1, 2};
    chk("t1_ngrants", 64'(gnt_log.size()), 64'd6);
    chk("t1_nrv", 64'(rv_log.size()), 64'd6);
    for (int i = 0; i < 6; i++) begin
      chk("t1_grant_order", 64'(at(gnt_log, i)), 64'(e1[i]));
      chk("t1_rv_master", 64'(at(rv_log, i)), 64'(e1[i]));
      chk("t1_rv_data", (i < rv_data.size()) ? 64'(rv_data[i]) : 64'hffff, 64'(32'h10 * (e1[i] + 1)));
    end

    // Lock under stall: master 1 held while master 0 joins.
    clear_logs();
    mreq[1].req = 1'b1; mreq[1].addr = 32'h200; sresp.gnt = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c == 1) begin mreq[0].req = 1'b1; mreq[0].addr = 32'h100; end
      @(negedge clk); chk("t2_lock_addr", 64'(sreq.addr), 64'h200);
      cyc();
    end
    sresp.gnt = 1'b1; cyc();
    mreq[1].req = 1'b0; cyc();
    mreq[0].req = 1'b0; sresp.gnt = 1'b0;
    sresp.rvalid = 1'b1; sresp.rdata = 32'h200; cyc();
    sresp.rdata = 32'h100; cyc();
    sresp = '0;
    chk("t2_first_grant", 64'(at(gnt_log, 0)), 64'd1);
    chk("t2_second_grant", 64'(at(gnt_log, 1)), 64'd0);
    chk("t2_rv0", 64'(at(rv_log, 0)), 64'd1);
    chk("t2_rv1", 64'(at(rv_log, 1)), 64'd0);

    // Full FIFO: two grants outstanding block a third issue until one returns.
    clear_logs();
    mreq[2].req = 1'b1; mreq[2].addr = 32'h300; sresp.gnt = 1'b1;
    cyc(); cyc();
    @(negedge clk); chk("t3_full_blocks", {63'd0, sreq.req}, 64'd0);
    cyc();
    sresp.rvalid = 1'b1; sresp.rdata = 32'h300;
    @(negedge clk); chk("t3_full_during_rv", {63'd0, sreq.req}, 64'd0);
    cyc();
    sresp.rvalid = 1'b0;
    @(negedge clk);
    chk("t3_reissue", {63'd0, sreq.req}, 64'd1);
    chk("t3_reissue_gnt", {63'd0, mresp[2].gnt}, 64'd1);
    cyc();
    mreq[2].req = 1'b0; sresp.gnt = 1'b0; sresp.rvalid = 1'b1;
    cyc(); cyc();
    sresp = '0;
    chk("t3_ngrants", 64'(gnt_log.size()), 64'd3);

    // Responses delayed 3 and 4 cycles return in issue order.
    clear_logs();
    mreq[2].req = 1'b1; mreq[2].addr = 32'hA2; sresp.gnt = 1'b1; cyc();
    mreq[2].req = 1'b0; mreq[0].req = 1'b1; mreq[0].addr = 32'hA0; cyc();
    mreq[0].req = 1'b0; sresp.gnt = 1'b0; cyc();
    sresp.rvalid = 1'b1; sresp.rdata = 32'hA2; cyc();
    sresp.rvalid = 1'b0; cyc();
    sresp.rvalid = 1'b1; sresp.rdata = 32'hA0; cyc();
    sresp = '0;
    chk("t4_grant0", 64'(at(gnt_log, 0)), 64'd2);
    chk("t4_grant1", 64'(at(gnt_log, 1)), 64'd0);
    chk("t4_rv0", 64'(at(rv_log, 0)), 64'd2);
    chk("t4_rv1", 64'(at(rv_log, 1)), 64'd0);
    chk("t4_rd0", (rv_data.size() > 0) ? 64'(rv_data[0]) : 64'hffff, 64'hA2);
    chk("t4_rd1", (rv_data.size() > 1) ? 64'(rv_data[1]) : 64'hffff, 64'hA0);

    // Stray response: dropped, sticky error from the next edge.
    chk("t5_err_before", {63'd0, perr}, 64'd0);
    sresp.rvalid = 1'b1; sresp.rdata = 32'hDEAD;
    @(negedge clk);
    any_rv = 1'b0;
    for (int i = 0; i < N; i++) any_rv |= mresp[i].rvalid;
    chk("t5_no_rvalid", {63'd0, any_rv}, 64'd0);
    chk("t5_err_not_yet", {63'd0, perr}, 64'd0);
    cyc();
    sresp = '0;
    chk("t5_err_set", {63'd0, perr}, 64'd1);
    cyc(); cyc(); cyc();
    chk("t5_err_sticky", {63'd0, perr}, 64'd1);

    // Reset mid-operation with one outstanding and a held selection.
    mreq[0].req = 1'b1; mreq[0].addr = 32'hB0; sresp.gnt = 1'b1; cyc();
    mreq[0].req = 1'b0; mreq[1].req = 1'b1; mreq[1].addr = 32'hB1; sresp.gnt = 1'b0; cyc();
    #3 rst_n = 1'b0;
    #1;
    any_rv = 1'b0;
    for (int i = 0; i < N; i++) any_rv |= mresp[i].rvalid | mresp[i].gnt | (|mresp[i].rdata);
    chk("t6_async_req", {31'd0, sreq.req, sreq.addr}, 64'd0);
    chk("t6_async_resp", {63'd0, any_rv}, 64'd0);
    chk("t6_async_err", {63'd0, perr}, 64'd0);
    mreq[1].req = 1'b0;
    mreq[0].req = 1'b1; mreq[0].addr = 32'hC0;
    mreq[2].req = 1'b1; mreq[2].addr = 32'hC2;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("t6_rr_zero_req", {63'd0, sreq.req}, 64'd1);
    chk("t6_rr_zero_addr", 64'(sreq.addr), 64'hC0);
    chk("t6_err_cleared", {63'd0, perr}, 64'd0);
    cyc();
    mreq = '0;
    cyc(); cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
